// File: rtl/dcache_ctrl_if.sv
// dcache_ctrl_if: CPU / cache-SRAM / main-memory bus bundle of the data-cache controller.
//   cpu_*  : pipeline request (req/we/addr/wdata in, rdata/ready out of the controller)
//   sram_* : single-port data SRAM (addr/wdata/we out, rdata in, combinational read)
//   mem_*  : main-memory req/ack handshake (req/we/addr/wdata out, rdata/ack in)
//   master : controller side, slave : environment side
interface dcache_ctrl_if #(
   parameter int AW  = 32,
   parameter int IDX = 4
);
   logic           cpu_req;
   logic           cpu_we;
   logic [AW-1:0]  cpu_addr;
   logic [31:0]    cpu_wdata;
   logic [31:0]    cpu_rdata;
   logic           cpu_ready;
   logic [IDX-1:0] sram_addr;
   logic [31:0]    sram_wdata;
   logic           sram_we;
   logic [31:0]    sram_rdata;
   logic           mem_req;
   logic           mem_we;
   logic [AW-1:0]  mem_addr;
   logic [31:0]    mem_wdata;
   logic [31:0]    mem_rdata;
   logic           mem_ack;
   modport master (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, sram_rdata, mem_rdata, mem_ack,
      output cpu_rdata, cpu_ready, sram_addr, sram_wdata, sram_we, mem_req, mem_we, mem_addr, mem_wdata
   );
   modport slave (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, sram_rdata, mem_rdata, mem_ack,
      input  cpu_rdata, cpu_ready, sram_addr, sram_wdata, sram_we, mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-through, no-write-allocate data-cache controller.
//   clk, rst           : clock, asynchronous active-high reset
//   i_flush            : invalidate all lines (IDLE with no request only)
//   bus (master)       : CPU request, cache data SRAM and main-memory handshake
//   o_hit_cnt/miss_cnt : wrapping performance counters, one count per access
module dcache_ctrl #(
   parameter int DEPTH = 16,
   parameter int AW    = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_flush,
   dcache_ctrl_if.master bus,
   output logic [31:0]   o_hit_cnt,
   output logic [31:0]   o_miss_cnt
);
   localparam int IDX = $clog2(DEPTH);
   localparam int TW  = AW - IDX - 2;
   typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} state_t;
   state_t         r_state, w_next;
   logic [DEPTH-1:0] r_valid;
   logic [TW-1:0]  r_tag [DEPTH];
   logic [AW-1:0]  r_addr;
   logic [31:0]    r_wdata, r_hit_cnt, r_miss_cnt;
   logic [IDX-1:0] w_idx;
   logic [TW-1:0]  w_tag;
   logic           w_hit, w_detect, w_fill;
   assign w_idx    = bus.cpu_addr[IDX+1:2];
   assign w_tag    = bus.cpu_addr[AW-1:IDX+2];
   assign w_hit    = r_valid[w_idx] && r_tag[w_idx] == w_tag;
   assign w_detect = r_state == IDLE && bus.cpu_req;
   assign w_fill   = r_state == RD_MISS && bus.mem_ack;
   assign o_hit_cnt  = r_hit_cnt;
   assign o_miss_cnt = r_miss_cnt;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:             if (bus.cpu_req) w_next = bus.cpu_we ? WR_THRU : (w_hit ? IDLE : RD_MISS);
         RD_MISS, WR_THRU: if (bus.mem_ack) w_next = IDLE;
         default:          w_next = IDLE;
      endcase
   end
   // A refill writes the returning word into the SRAM and forwards it to the CPU in the same cycle.
   always_comb begin
      bus.sram_addr  = w_idx;
      bus.sram_we    = (w_detect && bus.cpu_we && w_hit) || w_fill;
      bus.sram_wdata = w_fill ? bus.mem_rdata : bus.cpu_wdata;
      bus.cpu_rdata  = w_fill ? bus.mem_rdata : bus.sram_rdata;
      bus.cpu_ready  = (w_detect && !bus.cpu_we && w_hit) || (r_state != IDLE && bus.mem_ack);
      bus.mem_req    = r_state != IDLE;
      bus.mem_we     = r_state == WR_THRU;
      bus.mem_addr   = r_addr;
      bus.mem_wdata  = r_wdata;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid    <= '0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else begin
         if (w_detect) begin
            r_addr  <= bus.cpu_addr & ~AW'(3);
            r_wdata <= bus.cpu_wdata;
            if (w_hit) r_hit_cnt  <= r_hit_cnt + 32'd1;
            else       r_miss_cnt <= r_miss_cnt + 32'd1;
         end
         if (r_state == IDLE && !bus.cpu_req && i_flush) r_valid <= '0;
         else if (w_fill)                                r_valid[w_idx] <= 1'b1;
      end
   end
   // Tags are never reset; a cleared valid bit is enough to force a miss.
   always_ff @(posedge clk) begin
      if (w_fill) r_tag[w_idx] <= w_tag;
   end
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: scoreboard bench for dcache_ctrl with SRAM and variable-latency memory models.
module tb_dcache_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic [31:0] hit_cnt, miss_cnt;
   int          n_tests = 0, n_fail = 0, sram_wr = 0, lat = 3, cnt = 0, swr;
   logic        ack = 1'b0;
   logic [31:0] exp_q [$];
   bit   [31:0] sram [16];
   bit   [31:0] mm [1024];
   bit          mwr [1024];
   bit   [31:0] gm [1024];
   bit          gwr [1024];

   dcache_ctrl_if #(.AW(32), .IDX(4)) bus ();
   dcache_ctrl #(.DEPTH(16), .AW(32)) dut (
      .clk(clk), .rst(rst), .i_flush(flush), .bus(bus),
      .o_hit_cnt(hit_cnt), .o_miss_cnt(miss_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] dflt(input logic [9:0] w);
      return (w == 10'h10) ? 32'hDEADBEEF : {12'hA5C, 10'h0, w};
   endfunction

   function automatic logic [31:0] gold(input logic [31:0] a);
      return gwr[a[11:2]] ? gm[a[11:2]] : dflt(a[11:2]);
   endfunction

   assign bus.sram_rdata = sram[bus.sram_addr];
   always @(posedge clk) if (bus.sram_we) sram[bus.sram_addr] <= bus.sram_wdata;
   always @(negedge clk) if (bus.sram_we) sram_wr++;

   assign bus.mem_ack   = ack;
   assign bus.mem_rdata = ack ? (mwr[bus.mem_addr[11:2]] ? mm[bus.mem_addr[11:2]] : dflt(bus.mem_addr[11:2])) : 32'h0;
   always @(posedge clk) begin
      if (rst) begin
         cnt <= 0;
         ack <= 1'b0;
      end else if (ack) begin
         cnt <= 0;
         ack <= 1'b0;
         if (bus.mem_we) begin
            mm[bus.mem_addr[11:2]]  <= bus.mem_wdata;
            mwr[bus.mem_addr[11:2]] <= 1'b1;
         end
      end else if (bus.mem_req) begin
         cnt <= cnt + 1;
         ack <= (cnt + 1 >= lat - 1);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && bus.cpu_req && bus.cpu_ready && !bus.cpu_we) begin
         if (exp_q.size() == 0) check("rdata_unexpected", 32'd1, 32'd0);
         else                   check("rdata", bus.cpu_rdata, exp_q.pop_front());
      end
   end

   task automatic access(input string tg, input logic we, input logic [31:0] a, input logic [31:0] d,
                         input int exp_n, input logic exp_swe);
      int   n = 0;
      logic s0;
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = we;
      bus.cpu_addr  = a;
      bus.cpu_wdata = d;
      if (!we) exp_q.push_back(gold(a));
      @(negedge clk);
      s0 = bus.sram_we;
      while (!bus.cpu_ready && n < 40) begin
         n++;
         @(negedge clk);
      end
      check({tg, "_lat"}, n, exp_n);
      check({tg, "_swe"}, {31'd0, s0}, {31'd0, exp_swe});
      if (n > 0) begin
         check({tg, "_maddr"}, bus.mem_addr, a & ~32'd3);
         check({tg, "_mwe"}, {31'd0, bus.mem_we}, {31'd0, we});
      end
      if (we) begin
         gm[a[11:2]]  = d;
         gwr[a[11:2]] = 1'b1;
      end
      @(posedge clk);
      #1 bus.cpu_req = 1'b0;
   endtask

   initial begin
      bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_hit", hit_cnt, 0);
      check("rst_miss", miss_cnt, 0);
      check("rst_mreq", {31'd0, bus.mem_req}, 0);
      check("rst_maddr", bus.mem_addr, 0);
      check("rst_swe", {31'd0, bus.sram_we}, 0);
      check("rst_rdy", {31'd0, bus.cpu_ready}, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      access("ld40_miss", 0, 32'h40, 0, 3, 0);
      check("miss1", miss_cnt, 1);
      access("ld40_hit", 0, 32'h40, 0, 0, 0);
      check("hit1", hit_cnt, 1);
      access("ld80_conf", 0, 32'h80, 0, 3, 0);
      access("ld40_again", 0, 32'h40, 0, 3, 0);
      check("miss3", miss_cnt, 3);
      access("st40_hit", 1, 32'h40, 32'h12345678, 3, 1);
      access("ld40_new", 0, 32'h40, 0, 0, 0);
      check("hit3", hit_cnt, 3);
      swr = sram_wr;
      access("st100_miss", 1, 32'h100, 32'hCAFEF00D, 3, 0);
      check("st100_nosram", sram_wr, swr);
      check("st100_mem", mm[10'h40], 32'hCAFEF00D);
      access("ld100_noalloc", 0, 32'h100, 0, 3, 0);
      for (int i = 1; i <= 4; i++) access("fill", 0, 32'h200 + 4 * i, 0, 3, 0);
      flush = 1'b1;
      access("flush_req", 0, 32'h204, 0, 0, 0);
      flush = 1'b0;
      access("after_flush_req", 0, 32'h208, 0, 0, 0);
      flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      for (int i = 1; i <= 4; i++) access("flushed", 0, 32'h200 + 4 * i, 0, 3, 0);
      check("hit5", hit_cnt, 5);
      check("miss13", miss_cnt, 13);
      lat = 5;
      access("ld300_lat5", 0, 32'h300, 0, 5, 0);
      lat = 2;
      access("st304_min", 1, 32'h304, 32'h0BADF00D, 2, 0);
      check("miss15", miss_cnt, 15);
      lat = 10;
      swr = sram_wr;
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h404;
      repeat (3) @(negedge clk);
      check("pre_rst_mreq", {31'd0, bus.mem_req}, 1);
      rst = 1'b1;
      #1;
      check("async_mreq", {31'd0, bus.mem_req}, 0);
      check("async_hit", hit_cnt, 0);
      check("async_miss", miss_cnt, 0);
      @(posedge clk); #1 bus.cpu_req = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      check("rst_nosram", sram_wr, swr);
      lat = 3;
      access("ld208_inval", 0, 32'h208, 0, 3, 0);
      check("post_rst_miss", miss_cnt, 1);
      check("post_rst_hit", hit_cnt, 0);
      repeat (2) @(posedge clk);
      check("queue_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-through, no-write-allocate data-cache controller sitting between the pipeline's memory stage and the single-port cache data SRAM (`cache_sram`, combinational read, synchronous write). It holds the tag/valid arrays, decides hit or miss, drives the SRAM address, write data and write enable, and runs a req/ack handshake to main memory for read refills and write-through stores. It also keeps hit and miss counters for performance monitoring.

## Interface
- `DEPTH`, 16: number of cache lines, one 32-bit word per line; must be a power of two.
- `AW`, 32: CPU/memory byte-address width.
- `IDX`, $clog2(DEPTH): index width, derived and not overridden.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `cpu_req`  in  1: access request; held stable with address and data until `cpu_ready`.
- `cpu_we`  in  1: 1 = store, 0 = load.
- `cpu_addr`  in  AW: byte address; bits [1:0] ignored.
- `cpu_wdata`  in  32: store data.
- `cpu_rdata`  out  32: load data, valid when `cpu_ready` and `!cpu_we`.
- `cpu_ready`  out  1: access completes this cycle; stall pipeline while `cpu_req && !cpu_ready`.
- `flush`  in  1: invalidate all lines; honoured only in IDLE with `cpu_req`=0.
- `sram_addr`  out  IDX: SRAM line index.
- `sram_wdata`  out  32: SRAM write data.
- `sram_we`  out  1: SRAM write enable.
- `sram_rdata`  in  32: SRAM read data (combinational from `sram_addr`).
- `mem_req`  out  1: memory request, held until `mem_ack`.
- `mem_we`  out  1: memory write.
- `mem_addr`  out  AW: word-aligned memory address ([1:0]=0).
- `mem_wdata`  out  32: memory write data.
- `mem_rdata`  in  32: memory read data, valid in the `mem_ack` cycle.
- `mem_ack`  in  1: one-cycle completion pulse.
- `hit_cnt`, `miss_cnt`  out  32: performance counters.

## Operation
- Address split: index = `cpu_addr[IDX+1:2]`, tag = `cpu_addr[AW-1:IDX+2]`.
- Hit = `valid[index] && tag_ram[index]==tag`.
- `sram_addr` = index in all states.
- FSM states: IDLE, RD_MISS, WR_THRU.
- IDLE, load hit:
  - `cpu_ready`=1 combinationally.
  - `cpu_rdata`=`sram_rdata`.
  - `hit_cnt`+1.
  - Stay in IDLE.
- IDLE, load miss:
  - Register the word-aligned address.
  - Go to RD_MISS.
  - `miss_cnt`+1.
- RD_MISS:
  - `mem_req`=1, `mem_we`=0.
  - On `mem_ack`:
    - `sram_we`=1 and `sram_wdata`=`mem_rdata`.
    - Set tag and valid for the index.
    - `cpu_ready`=1 and `cpu_rdata`=`mem_rdata`.
    - Return to IDLE.
- IDLE, store:
  - On hit, `sram_we`=1 and `sram_wdata`=`cpu_wdata` in this cycle, and `hit_cnt`+1.
  - On miss, no SRAM write and no allocate; `miss_cnt`+1.
  - Either way, register address and data, then go to WR_THRU.
- WR_THRU:
  - `mem_req`=1, `mem_we`=1, `mem_wdata`=registered data.
  - On `mem_ack`, `cpu_ready`=1 and return to IDLE.
- `flush` (IDLE, no request): clears all valid bits at the next edge. Tags are unchanged.
- Counters wrap modulo 2^32 and count once per access, at detection in IDLE.
- `sram_we` is asserted only in the two cases above. Otherwise it is 0 and `sram_wdata` = `cpu_wdata`.

## Timing
- Reset values:
  - State IDLE, all valid bits 0, counters 0.
  - `mem_req`/`mem_we`=0, `mem_addr`/`mem_wdata`=0.
  - `sram_we`=0, `cpu_ready`=0 unless an IDLE hit is presented.
- Load hit: 0 stall cycles.
- Load miss: ready in the `mem_ack` cycle, i.e. 1 + memory latency cycles after the request.
- Store: ready in the `mem_ack` cycle, minimum 2 cycles.
- `mem_req` rises the cycle after miss/store detection and falls the cycle after `mem_ack`. Address and data are stable throughout.
- `mem_ack` outside RD_MISS/WR_THRU is ignored.
- `flush` together with `cpu_req`: the request wins and `flush` is ignored that cycle.
- `rst` mid-transaction: `mem_req` drops asynchronously, the transaction is abandoned, all lines are invalidated, and no SRAM write occurs.
- A load to the same index immediately after a fill hits, with the new data visible through the combinational read.

## Test plan
- Reset, then load 0x0000_0040 with memory returning 0xDEAD_BEEF after 3 cycles:
  - `cpu_ready` asserts in the ack cycle with 0xDEAD_BEEF.
  - `miss_cnt`=1.
  - Reloading the same address gives a 0-stall hit and `hit_cnt`=1.
- Conflict: load 0x040, then 0x080 (index 0 for both with DEPTH=16, since bits [5:2]=0):
  - The second access misses and refills.
  - Reloading 0x040 misses again; `miss_cnt`=3.
- Store hit 0x040 ← 0x1234_5678:
  - `sram_we` pulses in the detect cycle.
  - `mem_we` write-through runs, then a load of 0x040 hits with 0x1234_5678.
- Store miss 0x100:
  - No `sram_we`; the memory write completes.
  - A subsequent load of 0x100 misses, showing no allocate.
- `flush` in IDLE after filling 4 lines: all 4 lines then miss. `flush` asserted together with `cpu_req` has no effect.
- Assert `rst` 2 cycles into RD_MISS:
  - `mem_req`=0 immediately and no SRAM write occurs.
  - Counters are 0, and the previously filled line misses.
